braille_cell_scan_sequencer: RTL



---
 rtl/braille_cell_scan_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/braille_cell_scan_sequencer.sv
// braille_cell_scan_sequencer
// Sequences one 5-row x 2-column braille actuator cell (10 dots) through its
// row/column H-bridge drivers one dot at a time: latch a pattern, wait for a
// trigger, then pulse every dot set or clear with dead time before each pulse.
// Completion is flagged by a one-clock active-low trigger_out_n pulse.
// Optional build macro: BRAILLE_SKIP_UNCHANGED_EN -- when defined, dots whose
// latched target already matches dot_state are skipped (2 clocks per dot).
module braille_cell_scan_sequencer #(
    parameter int PULSE_CYCLES = 1000,
    parameter int DEAD_CYCLES  = 16,
    parameter int CNT_W        = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_n,
    input  logic [9:0]  frame_data,
    input  logic        latch_data_n,
    input  logic        trigger_in_n,
    output logic [4:0]  rows,
    output logic [1:0]  cols,
    output logic [4:0]  rows_enable,
    output logic [1:0]  cols_enable,
    output logic [9:0]  rows_hbrige,
    output logic [3:0]  cols_hbrige,
    output logic        trigger_out_n,
    output logic        busy,
    output logic [9:0]  dot_state
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DEAD,
        PULSE,
        NEXT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [3:0]       LAST_DOT   = 4'd9;

    state_t           state;
    logic [3:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [9:0]       work;
    logic [9:0]       pending;
    logic             pending_valid;

    logic latch_cur;
    logic latch_prev;
    logic trig_cur;
    logic trig_prev;
    logic latch_fall;
    logic trig_fall;

    // One-hot row select for a dot index (row = idx/2).
    function automatic logic [4:0] row_select(input logic [3:0] dot);
        row_select = 5'd1 << dot[3:1];
    endfunction

    // One-hot column select for a dot index (col = idx%2).
    function automatic logic [1:0] col_select(input logic [3:0] dot);
        col_select = 2'd1 << dot[0];
    endfunction

    // Row H-bridge word: {hi,lo}=10 raises the dot, 01 lowers it.
    function automatic logic [9:0] row_bridge(input logic [3:0] dot, input logic raise);
        logic [9:0] pair;
        pair = raise ? 10'b10 : 10'b01;
        row_bridge = pair << {dot[3:1], 1'b0};
    endfunction

    // Column H-bridge word: opposite polarity to the row so current flows through the dot.
    function automatic logic [3:0] col_bridge(input logic [3:0] dot, input logic raise);
        logic [3:0] pair;
        pair = raise ? 4'b0001 : 4'b0010;
        col_bridge = pair << {dot[0], 1'b0};
    endfunction

    // Registered copies of the strobes; an edge is seen when the older copy is high and the newer low.
    always_ff @(posedge clock) begin
        if (reset) begin
            latch_cur  <= 1'b1;
            latch_prev <= 1'b1;
            trig_cur   <= 1'b1;
            trig_prev  <= 1'b1;
        end else begin
            latch_cur  <= latch_data_n;
            latch_prev <= latch_cur;
            trig_cur   <= trigger_in_n;
            trig_prev  <= trig_cur;
        end
    end

    assign latch_fall = latch_prev & ~latch_cur;
    assign trig_fall  = trig_prev & ~trig_cur;

    // Main sequencer: state, dot index, timer, latched frames and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            cnt           <= '0;
            work          <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            dot_state     <= '0;
            busy          <= 1'b0;
            trigger_out_n <= 1'b1;
            rows          <= '0;
            cols          <= '0;
            rows_enable   <= '0;
            cols_enable   <= '0;
            rows_hbrige   <= '0;
            cols_hbrige   <= '0;
        end else begin
            trigger_out_n <= 1'b1;
            if (state != IDLE && enable_n) begin
                state       <= IDLE;
                busy        <= 1'b0;
                cnt         <= '0;
                rows        <= '0;
                cols        <= '0;
                rows_enable <= '0;
                cols_enable <= '0;
                rows_hbrige <= '0;
                cols_hbrige <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (trig_fall && pending_valid && !enable_n) begin
                            work          <= pending;
                            pending_valid <= 1'b0;
                            idx           <= '0;
                            cnt           <= '0;
                            busy          <= 1'b1;
                            state         <= SCAN;
                        end
                    end
                    SCAN: begin
                        cnt <= '0;
`ifdef BRAILLE_SKIP_UNCHANGED_EN
                        if (work[idx] == dot_state[idx]) begin
                            state <= NEXT;
                        end else begin
                            state <= DEAD;
                        end
`else
                        state <= DEAD;
`endif
                    end
                    DEAD: begin
                        if (cnt == DEAD_LAST) begin
                            cnt         <= '0;
                            state       <= PULSE;
                            rows        <= row_select(idx);
                            cols        <= col_select(idx);
                            rows_enable <= row_select(idx);
                            cols_enable <= col_select(idx);
                            rows_hbrige <= row_bridge(idx, work[idx]);
                            cols_hbrige <= col_bridge(idx, work[idx]);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    PULSE: begin
                        if (cnt == PULSE_LAST) begin
                            cnt         <= '0;
                            state       <= NEXT;
                            rows        <= '0;
                            cols        <= '0;
                            rows_enable <= '0;
                            cols_enable <= '0;
                            rows_hbrige <= '0;
                            cols_hbrige <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    NEXT: begin
                        dot_state[idx] <= work[idx];
                        if (idx == LAST_DOT) begin
                            state         <= DONE;
                            trigger_out_n <= 1'b0;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SCAN;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
            if (latch_fall) begin
                pending       <= frame_data;
                pending_valid <= 1'b1;
            end
        end
    end

    // A driver pair must never have both halves on, and only one row/column may be driven.
    assert property (@(posedge clock) disable iff (reset)
        ((rows_hbrige & (rows_hbrige >> 1) & 10'h155) == 10'h000) &&
        ((cols_hbrige & (cols_hbrige >> 1) & 4'h5) == 4'h0));

    assert property (@(posedge clock) disable iff (reset)
        $onehot0(rows_enable) && $onehot0(cols_enable));

endmodule
